// File: rtl/prog_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem_pkg
// Description : Shared constants for the program memory loader: default
//               geometry and the mode/state encoding reported on `mode`.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_mem_pkg;

  localparam int INST_W_DEF = 68;
  localparam int ADDR_W_DEF = 5;
  localparam int DEPTH_DEF  = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_RUN  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pm_ram.sv
`default_nettype none
// ============================================================================
// Module      : pm_ram
// Description : Simple dual-port memory, INST_W x DEPTH. Synchronous write
//               port (we/waddr/wdata) and synchronous read port
//               (re/raddr/rdata). No reset so it maps onto block RAM; the
//               read register holds its value while re is low.
// Ports       : clk; we, waddr, wdata; re, raddr, rdata
// Revision    : 1.0 - initial release
// ============================================================================
module pm_ram #(
  parameter int INST_W = 68,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [INST_W-1:0] rdata
);

  logic [INST_W-1:0] mem_q [DEPTH];
  logic [INST_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/prog_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem_loader
// Description : Program memory with a sequential valid/ready loader, an
//               IDLE/LOAD/RUN mode FSM and a 1-cycle-latency fetch port with
//               stall hold and out-of-range detection.
// Ports       : clk, rst (async, active high)
//               load_start/load_len/load_valid/load_data -> load_ready/load_done
//               fetch_req/fetch_addr/fetch_stall -> fetch_gnt/fetch_valid/
//               fetch_inst/fetch_err
//               mode : 0 IDLE, 1 LOAD, 2 RUN
// Revision    : 1.0 - initial release
// ============================================================================
module prog_mem_loader
  import prog_mem_pkg::*;
#(
  parameter int                INST_W   = INST_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DEPTH    = DEPTH_DEF,
  parameter logic [INST_W-1:0] NOP_INST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_valid,
  input  logic [INST_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  input  logic              fetch_stall,
  output logic              fetch_valid,
  output logic [INST_W-1:0] fetch_inst,
  output logic              fetch_err,
  output logic [1:0]        mode
);

  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] c_one   = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic              load_done_q, load_done_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              fetch_err_q, fetch_err_d;

  logic [ADDR_W:0]   len_clamped;
  logic              write_en;
  logic              load_finish;
  logic              in_run;
  logic              addr_oob;
  logic              hold;
  logic [INST_W-1:0] ram_rdata;

  assign len_clamped = (load_len > c_depth) ? c_depth : load_len;
  // A restart request takes priority over any word offered in the same cycle.
  assign write_en    = (state_q == ST_LOAD) && load_valid && !load_start && (wr_ptr_q < len_q);
  // Session ends on the last write, or immediately when the length is zero.
  assign load_finish = (state_q == ST_LOAD) && !load_start &&
                       ((len_q == '0) || (write_en && (wr_ptr_q == (len_q - c_one))));
  assign in_run      = (state_q == ST_RUN);
  assign addr_oob    = ({1'b0, fetch_addr} >= c_depth);
  assign hold        = fetch_valid_q && fetch_stall;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------- next-state comb
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load_start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (load_start)       state_d = ST_LOAD;
        else if (load_finish) state_d = ST_RUN;
      end
      ST_RUN:  if (load_start) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------- output comb
  always_comb begin
    load_ready = (state_q == ST_LOAD);
    mode       = state_q;
    fetch_gnt  = fetch_req && in_run && !load_start && !hold;
  end

  // ------------------------------------------------------------ datapath comb
  always_comb begin
    len_d         = len_q;
    wr_ptr_d      = wr_ptr_q;
    load_done_d   = load_finish;
    fetch_valid_d = 1'b0;
    fetch_err_d   = 1'b0;

    if (load_start) begin
      len_d    = len_clamped;
      wr_ptr_d = '0;
    end else if (write_en) begin
      wr_ptr_d = wr_ptr_q + c_one;
    end

    if (fetch_gnt) begin
      fetch_valid_d = 1'b1;
      fetch_err_d   = addr_oob;
    end else if (hold && in_run && !load_start) begin
      fetch_valid_d = fetch_valid_q;
      fetch_err_d   = fetch_err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q         <= '0;
      wr_ptr_q      <= '0;
      load_done_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      len_q         <= len_d;
      wr_ptr_q      <= wr_ptr_d;
      load_done_q   <= load_done_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  // The RAM read register only updates on a grant, so it naturally holds the
  // stalled instruction; out-of-range and idle cycles are masked to NOP here.
  pm_ram #(
    .INST_W (INST_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (write_en),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (load_data),
    .re    (fetch_gnt && !addr_oob),
    .raddr (fetch_addr),
    .rdata (ram_rdata)
  );

  assign load_done   = load_done_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_err   = fetch_err_q;
  assign fetch_inst  = (fetch_valid_q && !fetch_err_q) ? ram_rdata : NOP_INST;

endmodule
`default_nettype wire

// File: tb/tb_prog_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_mem_loader
// Description : Self-checking bench for prog_mem_loader. Two instances
//               (DEPTH 32 and DEPTH 24) share one stimulus stream and are
//               each compared against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [5:0]  load_len;
  logic        load_valid;
  logic [67:0] load_data;
  logic        fetch_req;
  logic [4:0]  fetch_addr;
  logic        fetch_stall;

  logic        load_ready_o  [2];
  logic        load_done_o   [2];
  logic        fetch_gnt_o   [2];
  logic        fetch_valid_o [2];
  logic [67:0] fetch_inst_o  [2];
  logic        fetch_err_o   [2];
  logic [1:0]  mode_o        [2];

  always #5 clk = ~clk;

  prog_mem_loader #(.INST_W(68), .ADDR_W(5), .DEPTH(32), .NOP_INST(68'h0)) dut32 (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready_o[0]),
    .load_done(load_done_o[0]), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt_o[0]), .fetch_stall(fetch_stall), .fetch_valid(fetch_valid_o[0]),
    .fetch_inst(fetch_inst_o[0]), .fetch_err(fetch_err_o[0]), .mode(mode_o[0]));

  prog_mem_loader #(.INST_W(68), .ADDR_W(5), .DEPTH(24), .NOP_INST(68'h0)) dut24 (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready_o[1]),
    .load_done(load_done_o[1]), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt_o[1]), .fetch_stall(fetch_stall), .fetch_valid(fetch_valid_o[1]),
    .fetch_inst(fetch_inst_o[1]), .fetch_err(fetch_err_o[1]), .mode(mode_o[1]));

  // ---------------------------------------------------------------- scoring
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
  endtask

  // ---------------------------------------------------------- reference model
  int          dep     [2] = '{32, 24};
  int          m_mode  [2];
  int          m_len   [2];
  int          m_wp    [2];
  bit          m_done  [2];
  bit          m_fv    [2];
  bit          m_ferr  [2];
  logic [67:0] m_inst  [2];
  bit          m_instv [2];
  logic [67:0] m_mem   [2][32];
  bit          m_memv  [2][32];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_len[k] = 0; m_wp[k] = 0; m_done[k] = 0;
      m_fv[k] = 0; m_ferr[k] = 0; m_inst[k] = '0; m_instv[k] = 1;
    end
  endtask

  function automatic bit model_gnt(int k);
    return fetch_req && (m_mode[k] == 2) && !load_start && !(m_fv[k] && fetch_stall);
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit stalled;
      stalled = m_fv[k] && fetch_stall && (m_mode[k] == 2) && !load_start;
      if (model_gnt(k)) begin
        m_fv[k] = 1;
        if (int'(fetch_addr) >= dep[k]) begin
          m_ferr[k] = 1; m_inst[k] = '0; m_instv[k] = 1;
        end else begin
          m_ferr[k] = 0; m_inst[k] = m_mem[k][fetch_addr]; m_instv[k] = m_memv[k][fetch_addr];
        end
      end else if (!stalled) begin
        m_fv[k] = 0; m_ferr[k] = 0; m_inst[k] = '0; m_instv[k] = 1;
      end
      m_done[k] = 0;
      if (load_start) begin
        m_mode[k] = 1;
        m_len[k]  = (int'(load_len) > dep[k]) ? dep[k] : int'(load_len);
        m_wp[k]   = 0;
      end else if (m_mode[k] == 1) begin
        if (m_len[k] == 0) begin
          m_mode[k] = 2; m_done[k] = 1;
        end else if (load_valid) begin
          m_mem[k][m_wp[k]] = load_data;
          m_memv[k][m_wp[k]] = 1;
          m_wp[k]++;
          if (m_wp[k] == m_len[k]) begin
            m_mode[k] = 2; m_done[k] = 1;
          end
        end
      end
    end
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s mode[%0d]", tag, k), 68'(mode_o[k]), 68'(m_mode[k]));
      chk($sformatf("%s load_done[%0d]", tag, k), 68'(load_done_o[k]), 68'(m_done[k]));
      chk($sformatf("%s fetch_valid[%0d]", tag, k), 68'(fetch_valid_o[k]), 68'(m_fv[k]));
      chk($sformatf("%s fetch_err[%0d]", tag, k), 68'(fetch_err_o[k]), 68'(m_ferr[k]));
      if (m_instv[k]) chk($sformatf("%s fetch_inst[%0d]", tag, k), fetch_inst_o[k], m_inst[k]);
    end
  endtask

  task automatic check_comb(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s load_ready[%0d]", tag, k), 68'(load_ready_o[k]), 68'(m_mode[k] == 1));
      chk($sformatf("%s fetch_gnt[%0d]", tag, k), 68'(fetch_gnt_o[k]), 68'(model_gnt(k)));
    end
  endtask

  // One clock: check combinational outputs, take the edge, check registers.
  task automatic cyc(input string tag);
    #1;
    check_comb(tag);
    @(posedge clk);
    model_step();
    #1;
    check_regs(tag);
  endtask

  task automatic idle_inputs();
    load_start = 0; load_len = '0; load_valid = 0; load_data = '0;
    fetch_req = 0; fetch_addr = '0; fetch_stall = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_regs("reset");
    check_comb("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [67:0] rnd68();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[67:0];
  endfunction

  // ------------------------------------------------------ directed load table
  typedef struct {
    bit          ls;
    logic [5:0]  len;
    bit          lv;
    logic [67:0] ld;
    bit          fr;
    logic [4:0]  fa;
    bit          e_ready;
    bit          e_gnt;
    logic [1:0]  e_mode;
    bit          e_done;
    bit          e_fv;
    logic [67:0] e_inst;
  } vec_t;

  function automatic vec_t mk(bit ls, logic [5:0] len, bit lv, logic [67:0] ld, bit fr,
                              logic [4:0] fa, bit er, bit eg, logic [1:0] em, bit ed,
                              bit ev, logic [67:0] ei);
    vec_t v;
    v.ls = ls; v.len = len; v.lv = lv; v.ld = ld; v.fr = fr; v.fa = fa;
    v.e_ready = er; v.e_gnt = eg; v.e_mode = em; v.e_done = ed; v.e_fv = ev; v.e_inst = ei;
    return v;
  endfunction

  vec_t tbl [10];

  initial begin
    logic [67:0] word_b;
    int          writes;
    bit          done_seen;

    tbl[0] = mk(1, 6'd4, 0, 68'h0, 0, 5'd0, 0, 0, 2'd1, 0, 0, 68'h0);
    tbl[1] = mk(0, 6'd0, 1, 68'h1, 0, 5'd0, 1, 0, 2'd1, 0, 0, 68'h0);
    tbl[2] = mk(0, 6'd0, 1, 68'h2, 0, 5'd0, 1, 0, 2'd1, 0, 0, 68'h0);
    tbl[3] = mk(0, 6'd0, 1, 68'h3, 0, 5'd0, 1, 0, 2'd1, 0, 0, 68'h0);
    tbl[4] = mk(0, 6'd0, 1, 68'h4, 0, 5'd0, 1, 0, 2'd2, 1, 0, 68'h0);
    tbl[5] = mk(0, 6'd0, 0, 68'h0, 1, 5'd0, 0, 1, 2'd2, 0, 1, 68'h1);
    tbl[6] = mk(0, 6'd0, 0, 68'h0, 1, 5'd1, 0, 1, 2'd2, 0, 1, 68'h2);
    tbl[7] = mk(0, 6'd0, 0, 68'h0, 1, 5'd2, 0, 1, 2'd2, 0, 1, 68'h3);
    tbl[8] = mk(0, 6'd0, 0, 68'h0, 1, 5'd3, 0, 1, 2'd2, 0, 1, 68'h4);
    tbl[9] = mk(0, 6'd0, 0, 68'h0, 0, 5'd0, 0, 0, 2'd2, 0, 0, 68'h0);

    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 32; a++) begin
        m_mem[k][a] = '0; m_memv[k][a] = 0;
      end

    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    do_reset();

    // Load four words, then fetch them back.
    for (int i = 0; i < 10; i++) begin
      load_start = tbl[i].ls; load_len = tbl[i].len; load_valid = tbl[i].lv;
      load_data = tbl[i].ld; fetch_req = tbl[i].fr; fetch_addr = tbl[i].fa; fetch_stall = 0;
      #1;
      chk($sformatf("tbl%0d load_ready", i), 68'(load_ready_o[0]), 68'(tbl[i].e_ready));
      chk($sformatf("tbl%0d fetch_gnt", i), 68'(fetch_gnt_o[0]), 68'(tbl[i].e_gnt));
      cyc("tbl");
      chk($sformatf("tbl%0d mode", i), 68'(mode_o[0]), 68'(tbl[i].e_mode));
      chk($sformatf("tbl%0d load_done", i), 68'(load_done_o[0]), 68'(tbl[i].e_done));
      chk($sformatf("tbl%0d fetch_valid", i), 68'(fetch_valid_o[0]), 68'(tbl[i].e_fv));
      chk($sformatf("tbl%0d fetch_inst", i), fetch_inst_o[0], tbl[i].e_inst);
    end

    // Stall hold across back-to-back fetches of addr 2 then 3.
    fetch_req = 1; fetch_addr = 5'd2;
    cyc("stall");
    fetch_addr = 5'd3; fetch_stall = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("stall gnt_blocked", 68'(fetch_gnt_o[0]), 68'h0);
      cyc("stall");
      chk("stall inst_hold", fetch_inst_o[0], 68'h3);
    end
    fetch_stall = 0;
    cyc("stall");
    chk("stall inst_next", fetch_inst_o[0], 68'h4);
    idle_inputs();
    cyc("stall");

    // Out-of-range fetch on the 24-deep instance.
    fetch_req = 1; fetch_addr = 5'd30;
    cyc("oob");
    chk("oob valid24", 68'(fetch_valid_o[1]), 68'h1);
    chk("oob err24", 68'(fetch_err_o[1]), 68'h1);
    chk("oob inst24", fetch_inst_o[1], 68'h0);
    idle_inputs();
    cyc("oob");

    // Zero-length load goes LOAD then RUN with a done pulse.
    load_start = 1; load_len = 6'd0;
    cyc("len0");
    chk("len0 mode_load", 68'(mode_o[0]), 68'h1);
    idle_inputs();
    cyc("len0");
    chk("len0 mode_run", 68'(mode_o[0]), 68'h2);
    chk("len0 done", 68'(load_done_o[0]), 68'h1);

    // Oversized length clamps to the implemented depth.
    load_start = 1; load_len = 6'd40;
    cyc("len40");
    load_start = 0;
    writes = 0; done_seen = 0;
    for (int i = 0; i < 50 && !done_seen; i++) begin
      load_valid = 1; load_data = rnd68();
      #1;
      if (load_ready_o[0]) writes++;
      cyc("len40");
      if (load_done_o[0]) done_seen = 1;
    end
    chk("len40 done_seen", 68'(done_seen), 68'h1);
    chk("len40 writes", 68'(writes), 68'd32);
    idle_inputs();

    // Gapped valid pattern, then a fetch sweep.
    load_start = 1; load_len = 6'd4;
    cyc("gap");
    load_start = 0;
    for (int i = 0; i < 6; i++) begin
      load_valid = (i != 1) && (i != 4);
      load_data = 68'hA0 + 68'(i);
      cyc("gap");
    end
    idle_inputs();
    for (int a = 0; a < 5; a++) begin
      fetch_req = (a < 4); fetch_addr = 5'(a);
      cyc("gap_sweep");
    end
    idle_inputs();

    // Reset in the middle of a load keeps the words already written.
    load_start = 1; load_len = 6'd5;
    cyc("midrst");
    load_start = 0;
    word_b = rnd68();
    load_valid = 1; load_data = rnd68();
    cyc("midrst");
    load_data = word_b;
    cyc("midrst");
    idle_inputs();
    do_reset();
    chk("midrst mode", 68'(mode_o[0]), 68'h0);
    load_start = 1; load_len = 6'd0;
    cyc("midrst");
    idle_inputs();
    cyc("midrst");
    fetch_req = 1; fetch_addr = 5'd1;
    cyc("midrst");
    chk("midrst word_b", fetch_inst_o[0], word_b);
    idle_inputs();

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        idle_inputs();
        do_reset();
      end
      load_start  = ($urandom_range(0, 29) == 0);
      load_len    = 6'($urandom_range(0, 40));
      load_valid  = 1'($urandom_range(0, 1));
      load_data   = rnd68();
      fetch_req   = ($urandom_range(0, 3) != 0);
      fetch_addr  = 5'($urandom_range(0, 31));
      fetch_stall = ($urandom_range(0, 3) == 0);
      cyc("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
- Parametrised successor to the 32x68 program memory.
- Adds a sequential loader with a valid/ready handshake, an auto-incrementing write pointer, and a mode FSM (IDLE/LOAD/RUN).
- Provides a fetch port with 1-cycle latency, stall hold and out-of-range detection.
- Sits between the boot/host loader and the fetch stage; the fetch stage only reads in RUN.

Parameters:
- INST_W, 68, instruction word width in bits.
- ADDR_W, 5, address width.
- DEPTH, 32, number of implemented words; must satisfy DEPTH <= 2**ADDR_W.
- NOP_INST, 0, value driven on fetch_inst when no valid instruction is present.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_start  in  1  begin a load session; sampled in any state.
- load_len  in  ADDR_W+1  number of words to load; values above DEPTH clamp to DEPTH.
- load_valid  in  1  load_data is valid.
- load_data  in  INST_W  word to write at the current write pointer.
- load_ready  out  1  block accepts a word this cycle.
- load_done  out  1  one-cycle pulse when the last word is written.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  fetch word address.
- fetch_gnt  out  1  request accepted this cycle.
- fetch_stall  in  1  consumer cannot take fetch_inst; hold the output.
- fetch_valid  out  1  fetch_inst is valid.
- fetch_inst  out  INST_W  fetched instruction.
- fetch_err  out  1  the accepted address was >= DEPTH; qualified by fetch_valid.
- mode  out  2  current state: 0 IDLE, 1 LOAD, 2 RUN.

Behaviour:
- Reset (async assert, synchronous release):
  - state = IDLE, write pointer wr_ptr = 0, stored length = 0.
  - fetch_valid = 0, fetch_err = 0, fetch_inst = NOP_INST, load_done = 0.
  - RAM contents are not cleared and are retained across reset.
- FSM transitions:
  - IDLE -> LOAD on load_start.
  - LOAD -> RUN when the last word is written.
  - RUN -> LOAD on load_start.
  - LOAD + load_start restarts the session: wr_ptr = 0, new load_len latched, previously written words retained.
- Entering LOAD:
  - Latch min(load_len, DEPTH) and clear wr_ptr.
  - If the clamped length is 0, go directly to RUN next cycle and pulse load_done.
- In LOAD:
  - load_ready = 1, combinational from state; load_ready = 0 in all other states.
  - On load_valid && load_ready: ram[wr_ptr] <= load_data, wr_ptr++.
  - On the write with wr_ptr == len-1: next state RUN, load_done = 1 for exactly one cycle.
- Fetch acceptance (combinational):
  - fetch_gnt = fetch_req && state==RUN && !load_start && !(fetch_valid && fetch_stall).
  - load_start wins over a simultaneous fetch_req.
- Fetch response, the cycle after a grant:
  - fetch_valid = 1.
  - fetch_inst = ram[fetch_addr]; if fetch_addr >= DEPTH, fetch_inst = NOP_INST and fetch_err = 1.
  - Latency is 1 cycle; back-to-back grants give one instruction per cycle.
- Stall: while fetch_valid && fetch_stall, fetch_inst, fetch_err and fetch_valid hold their values.
- Output clear: with no grant and no stall, fetch_valid = 0 next cycle and fetch_inst = NOP_INST (never X or Z).
- Leaving RUN (load_start): fetch_valid and fetch_err clear next cycle regardless of fetch_stall.
- No RAM read/write conflict exists, because writes occur only in LOAD and reads only in RUN.
- Reset mid-LOAD: session abandoned, state = IDLE; words already written stay in RAM.

Decomposition:
- Package prog_mem_pkg:
  - state encoding constants ST_IDLE=0, ST_LOAD=1, ST_RUN=2.
  - Default width/depth constants.
- Sub-module pm_ram:
  - simple dual-port memory, INST_W x DEPTH.
  - synchronous write port (we, waddr, wdata); synchronous read port (re, raddr, rdata).
  - no reset, so it can infer block RAM.
- Top level holds the FSM, wr_ptr, stall hold and range check.

Test Plan:
1. Reset then load_start with load_len=4 and words 68'h1..68'h4 on consecutive cycles: load_done pulses the cycle after the 4th write, mode=2; fetches of addr 0..3 return 1..4 with 1-cycle latency.
2. Back-to-back fetch of addr 2 then 3 with fetch_stall=1 during the first response: fetch_inst holds 68'h3 and fetch_gnt=0 until stall drops; then 68'h4 appears the next cycle.
3. DEPTH=24, fetch_addr=30 in RUN: fetch_valid=1, fetch_err=1, fetch_inst=NOP_INST.
4. load_len=0: mode goes 1 then 2 and load_done pulses with no RAM writes; load_len=40 with DEPTH=32: exactly 32 writes accepted.
5. Gaps in load_valid (pattern 1,0,1,1): wr_ptr advances only on valid cycles; contents verified by a fetch sweep.
6. rst asserted mid-LOAD after 2 of 5 words: mode=0 and outputs reset; after a fresh load of 0 words, a fetch of addr 1 returns the second previously written word.
